// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decode
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       released,
  output logic       key_strobe,
  output logic       frame_err,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          sample;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_p, brk_p;
  logic          shift_en, par_en, stop_ev, timeout, frame_ok;

  // Filtered clock flips only when the synced input has disagreed for FILTER_LEN samples
  assign sample = filt && !clk_s2 && (filt_cnt == FILT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt     <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2data;
      data_s2 <= data_s1;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_ev   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:   if (sample && !data_s2) state_nxt = DATA;
      DATA:   if (sample) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_nxt = PARITY;
              end
      PARITY: if (sample) begin
                par_en    = 1'b1;
                state_nxt = STOP;
              end
      STOP:   if (sample) begin
                stop_ev   = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !sample && to_cnt == TO_LAST) begin
      timeout   = 1'b1;
      state_nxt = IDLE;
    end
  end

  assign frame_ok = stop_ev && data_s2 && (^{shreg, par_bit});

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      ext_p      <= 1'b0;
      brk_p      <= 1'b0;
      scan_code  <= '0;
      extended   <= 1'b0;
      released   <= 1'b0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || sample) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      if (state == IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {data_s2, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par_bit <= data_s2;
      if (timeout) begin
        frame_err <= 1'b1;
        ext_p     <= 1'b0;
        brk_p     <= 1'b0;
      end else if (stop_ev) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          ext_p     <= 1'b0;
          brk_p     <= 1'b0;
        end else if (shreg == 8'hE0) begin
          ext_p <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_p <= 1'b1;
        end else begin
          scan_code  <= shreg;
          extended   <= ext_p;
          released   <= brk_p;
          key_strobe <= 1'b1;
          ext_p      <= 1'b0;
          brk_p      <= 1'b0;
        end
      end
    end
  end

  assign code_hi = scan_code[7:4];
  assign code_lo = scan_code[3:0];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] scan_code;
  logic       extended, released, key_strobe, frame_err;
  logic [3:0] code_hi, code_lo;

  int checks = 0;
  int errors = 0;
  int strobes = 0, errs = 0, both = 0, long_s = 0, long_e = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .scan_code(scan_code), .extended(extended), .released(released),
    .key_strobe(key_strobe), .frame_err(frame_err),
    .code_hi(code_hi), .code_lo(code_lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe) strobes++;
    if (frame_err) errs++;
    if (key_strobe && frame_err) both++;
    if (key_strobe && prev_s) long_s++;
    if (frame_err && prev_e) long_e++;
    prev_s = key_strobe;
    prev_e = frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2data = b;
    repeat (HALF) @(posedge clk);
    ps2clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic badpar);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ badpar);
    send_bit(1'b1);
    repeat (HALF) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] sc, input logic ex, input logic rl,
                         input int ns, input int ne);
    chk({tag, "_code"}, 32'(scan_code), 32'(sc));
    chk({tag, "_ext"}, 32'(extended), 32'(ex));
    chk({tag, "_rel"}, 32'(released), 32'(rl));
    chk({tag, "_strobes"}, 32'(strobes), 32'(ns));
    chk({tag, "_errs"}, 32'(errs), 32'(ne));
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_code", 32'(scan_code), 32'h0);
    chk("rst_flags", 32'({extended, released, key_strobe, frame_err}), 32'h0);
    chk("rst_nibbles", 32'({code_hi, code_lo}), 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    send_frame(8'h1C, 1'b0);
    chk_out("t1", 8'h1C, 1'b0, 1'b0, 1, 0);
    chk("t1_hi", 32'(code_hi), 32'h1);
    chk("t1_lo", 32'(code_lo), 32'hC);

    send_frame(8'hF0, 1'b0);
    chk("t2_nostrobe_f0", 32'(strobes), 32'd1);
    send_frame(8'h1C, 1'b0);
    chk_out("t2", 8'h1C, 1'b0, 1'b1, 2, 0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_out("t3a", 8'h75, 1'b1, 1'b0, 3, 0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk_out("t3b", 8'h75, 1'b1, 1'b1, 4, 0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    chk_out("t3c", 8'h74, 1'b1, 1'b1, 5, 0);

    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b1);
    chk_out("t4_bad", 8'h74, 1'b1, 1'b1, 5, 1);
    send_frame(8'h29, 1'b0);
    chk_out("t4_good", 8'h29, 1'b0, 1'b0, 6, 1);
    chk("t4_nibbles", 32'({code_hi, code_lo}), 32'h29);

    ps2data = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2clk = 1'b0;
    repeat (FL - 2) @(posedge clk);
    ps2clk = 1'b1;
    repeat (HALF) @(posedge clk);
    ps2data = 1'b1;
    repeat (HALF) @(posedge clk);
    send_frame(8'h1C, 1'b0);
    chk_out("t5_glitch", 8'h1C, 1'b0, 1'b0, 7, 1);

    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps2data = 1'b1;
    repeat (TO - 2 * HALF) @(posedge clk);
    @(negedge clk);
    chk("t5_before_to", 32'(errs), 32'd1);
    repeat (2 * HALF + 100) @(posedge clk);
    @(negedge clk);
    chk("t5_after_to", 32'(errs), 32'd2);
    send_frame(8'h1C, 1'b0);
    chk_out("t5_post", 8'h1C, 1'b0, 1'b0, 8, 2);

    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_rst_code", 32'(scan_code), 32'h0);
    chk("t6_rst_flags", 32'({extended, released, key_strobe, frame_err}), 32'h0);
    chk("t6_rst_nibbles", 32'({code_hi, code_lo}), 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(8'h75, 1'b0);
    chk_out("t6_post", 8'h75, 1'b0, 1'b0, 9, 2);

    chk("never_both", 32'(both), 32'd0);
    chk("strobe_1cyc", 32'(long_s), 32'd0);
    chk("err_1cyc", 32'(long_e), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
